// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, single outstanding imem request, one-entry skid buffer and redirect discard.
module if_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = 'h8000_0000,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_stall,
    input  logic            i_pc_load,
    input  logic [XLEN-1:0] i_pc_target,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [31:0]     i_imem_data,
    input  logic            i_imem_err,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic            o_valid,
    output logic            o_fetch_err
);
    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_pend_q, pc_pend_d;
    logic [31:0]     inst_q, inst_d, skid_inst_q, skid_inst_d;
    logic [XLEN-1:0] opc_q, opc_d, skid_pc_q, skid_pc_d;
    logic            valid_q, valid_d, ferr_q, ferr_d;
    logic            skid_err_q, skid_err_d, skid_v_q, skid_v_d;
    logic            req, ack, accept, consume, out_free;
    logic [XLEN-1:0] target;

    assign req      = (state_q == FETCH && !skid_v_q) || state_q == DISCARD;
    assign ack      = i_imem_ack && req;
    assign accept   = state_q == FETCH && ack && !i_pc_load;
    assign consume  = valid_q && !i_stall;
    assign out_free = (!valid_q || consume) && !skid_v_q;
    assign target   = {i_pc_target[XLEN-1:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_pend_d   = pc_pend_q;
        inst_d      = inst_q;
        opc_d       = opc_q;
        valid_d     = valid_q;
        ferr_d      = ferr_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_err_d  = skid_err_q;
        skid_v_d    = skid_v_q;
        if (state_q == IDLE)
            state_d = FETCH;
        if (i_pc_load) begin
            valid_d  = 1'b0;
            inst_d   = NOP;
            ferr_d   = 1'b0;
            skid_v_d = 1'b0;
            // A still-pending request must be drained before the new target can be issued
            if (!req || ack) begin
                pc_d    = target;
                state_d = FETCH;
            end else begin
                pc_pend_d = target;
                state_d   = DISCARD;
            end
        end else begin
            if (state_q == DISCARD && ack) begin
                pc_d    = pc_pend_q;
                state_d = FETCH;
            end
            if (accept)
                pc_d = pc_q + XLEN'(4);
            if (consume && skid_v_q) begin
                inst_d   = skid_inst_q;
                opc_d    = skid_pc_q;
                ferr_d   = skid_err_q;
                skid_v_d = accept;
            end else if (accept && out_free) begin
                inst_d  = i_imem_data;
                opc_d   = pc_q;
                ferr_d  = i_imem_err;
                valid_d = 1'b1;
            end else if (consume) begin
                valid_d = 1'b0;
                inst_d  = NOP;
                ferr_d  = 1'b0;
            end
            if (accept && !out_free) begin
                skid_inst_d = i_imem_data;
                skid_pc_d   = pc_q;
                skid_err_d  = i_imem_err;
                skid_v_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            pc_q        <= PC_RESET;
            pc_pend_q   <= PC_RESET;
            inst_q      <= NOP;
            opc_q       <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            skid_err_q  <= 1'b0;
            skid_v_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_pend_q   <= pc_pend_d;
            inst_q      <= inst_d;
            opc_q       <= opc_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_err_q  <= skid_err_d;
            skid_v_q    <= skid_v_d;
        end
    end

    assign o_imem_req  = req;
    assign o_imem_addr = pc_q;
    assign o_inst      = inst_q;
    assign o_pc        = opc_q;
    assign o_valid     = valid_q;
    assign o_fetch_err = ferr_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and random stimulus for if_stage against a queue-based delivery model.
module tb_if_stage;
    localparam logic [31:0] PC_RESET = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] XMASK    = 32'hA5A5_0000;

    logic        i_clk = 1'b0, i_rstn = 1'b0, i_stall = 1'b0, i_pc_load = 1'b0;
    logic        i_imem_ack = 1'b0, i_imem_err = 1'b0;
    logic [31:0] i_pc_target = '0, i_imem_data = '0;
    logic        o_imem_req, o_valid, o_fetch_err;
    logic [31:0] o_imem_addr, o_inst, o_pc;

    int checks = 0, failures = 0;

    always #5 i_clk = ~i_clk;

    if_stage dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_stall(i_stall), .i_pc_load(i_pc_load),
        .i_pc_target(i_pc_target), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data), .i_imem_err(i_imem_err),
        .o_inst(o_inst), .o_pc(o_pc), .o_valid(o_valid), .o_fetch_err(o_fetch_err)
    );

    typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic err;} ent_t;
    ent_t        q[$];
    logic [31:0] exp_pc, pend, disc_addr;
    bit          discarding, idle, mem_busy, noisy = 0, err_force = 0;
    int          mem_cnt, lat = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_pc     = PC_RESET;
        discarding = 0;
        idle       = 1;
        mem_busy   = 0;
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            i_rstn      = 1'b0;
            i_stall     = 1'($urandom);
            i_pc_load   = 1'($urandom);
            i_pc_target = $urandom;
            i_imem_ack  = 1'($urandom);
            i_imem_data = $urandom;
            i_imem_err  = 1'($urandom);
            @(posedge i_clk); #1;
        end
        model_reset();
    endtask

    task automatic check_reset();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_inst", o_inst, NOP);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_err", 32'(o_fetch_err), 32'd0);
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_addr", o_imem_addr, PC_RESET);
    endtask

    // One clock: check outputs against the model, play memory, clock, advance the model.
    task automatic cycle(input logic st, input logic ld, input logic [31:0] tgt);
        logic        req, ack, err;
        logic [31:0] addr, data;
        req  = o_imem_req;
        addr = o_imem_addr;
        chk("m_valid", 32'(o_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("m_inst", o_inst, q[0].inst);
            chk("m_pc", o_pc, q[0].pc);
            chk("m_err", 32'(o_fetch_err), 32'(q[0].err));
        end else begin
            chk("m_nop", o_inst, NOP);
            chk("m_err0", 32'(o_fetch_err), 32'd0);
        end
        chk("m_req", 32'(req), 32'(!idle && (discarding || q.size() < 2)));
        if (req)
            chk("m_addr", addr, discarding ? disc_addr : exp_pc);
        if (req && !mem_busy) begin
            mem_busy = 1;
            mem_cnt  = lat < 0 ? int'($urandom_range(3, 0)) : lat;
        end
        ack  = req && mem_busy && mem_cnt == 0;
        err  = ack && (err_force || (noisy && $urandom_range(7, 0) == 0));
        data = ack ? addr ^ XMASK : $urandom;
        i_rstn      = 1'b1;
        i_stall     = st;
        i_pc_load   = ld;
        i_pc_target = tgt;
        i_imem_ack  = ack || (!req && noisy && $urandom_range(3, 0) == 0);
        i_imem_data = data;
        i_imem_err  = err || (!ack && noisy && 1'($urandom));
        @(posedge i_clk); #1;
        if (mem_busy) begin
            if (ack) mem_busy = 0;
            else mem_cnt--;
        end
        if (ld) begin
            q.delete();
            if (!req || ack) begin
                exp_pc     = {tgt[31:2], 2'b00};
                discarding = 0;
            end else begin
                if (!discarding) disc_addr = addr;
                discarding = 1;
                pend       = {tgt[31:2], 2'b00};
            end
        end else begin
            if (q.size() > 0 && !st) q.delete(0);
            if (ack && discarding) begin
                discarding = 0;
                exp_pc     = pend;
            end else if (ack) begin
                q.push_back('{pc: exp_pc, inst: data, err: err});
                exp_pc = exp_pc + 32'd4;
            end
        end
        idle = 0;
    endtask

    initial begin
        reset_cycles(3);
        check_reset();
        // first fetch and streaming, zero-wait memory
        cycle(0, 0, 0);
        chk("first_req", 32'(o_imem_req), 32'd1);
        chk("first_addr", o_imem_addr, PC_RESET);
        cycle(0, 0, 0);
        chk("first_valid", 32'(o_valid), 32'd1);
        chk("s0_pc", o_pc, PC_RESET);
        chk("s0_inst", o_inst, PC_RESET ^ XMASK);
        cycle(0, 0, 0);
        chk("s1_pc", o_pc, PC_RESET + 32'd4);
        cycle(0, 0, 0);
        chk("s2_pc", o_pc, PC_RESET + 32'd8);
        chk("s2_inst", o_inst, (PC_RESET + 32'd8) ^ XMASK);
        // stall: skid takes one word, req drops, then drains in order
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0);
            chk("stall_hold", o_pc, PC_RESET + 32'd8);
            chk("stall_req", 32'(o_imem_req), 32'd0);
        end
        cycle(0, 0, 0);
        chk("drain_skid", o_pc, PC_RESET + 32'd12);
        chk("drain_req", 32'(o_imem_req), 32'd1);
        cycle(0, 0, 0);
        chk("drain_next", o_pc, PC_RESET + 32'd16);
        // redirect with nothing outstanding, 3-wait memory
        lat = 3;
        for (int i = 0; i < 20 && o_imem_req; i++) cycle(1, 0, 0);
        chk("idle_req", 32'(o_imem_req), 32'd0);
        cycle(1, 1, 32'h8000_0102);
        chk("rd_req", 32'(o_imem_req), 32'd1);
        chk("rd_addr", o_imem_addr, 32'h8000_0100);
        chk("rd_flush", 32'(o_valid), 32'd0);
        // redirect while a request is outstanding
        cycle(0, 1, 32'h100);
        for (int i = 0; i < 2; i++) begin
            chk("disc_addr", o_imem_addr, 32'h8000_0100);
            chk("disc_valid", 32'(o_valid), 32'd0);
            cycle(0, 0, 0);
        end
        cycle(0, 0, 0);
        chk("disc_done_addr", o_imem_addr, 32'h100);
        chk("disc_drop", 32'(o_valid), 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        cycle(0, 1, 32'h200);
        chk("coinc_req", 32'(o_imem_req), 32'd1);
        chk("coinc_addr", o_imem_addr, 32'h200);
        chk("coinc_drop", 32'(o_valid), 32'd0);
        // address wrap and fetch error
        lat = 0;
        cycle(0, 1, 32'hFFFF_FFFC);
        chk("wrap_addr0", o_imem_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        chk("wrap_addr1", o_imem_addr, 32'h0);
        chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
        err_force = 1;
        cycle(0, 0, 0);
        err_force = 0;
        chk("ferr_pc", o_pc, 32'h0);
        chk("ferr_set", 32'(o_fetch_err), 32'd1);
        cycle(0, 0, 0);
        chk("ferr_clr", 32'(o_fetch_err), 32'd0);
        // reset with skid full
        for (int i = 0; i < 10 && o_imem_req; i++) cycle(1, 0, 0);
        chk("skid_full_req", 32'(o_imem_req), 32'd0);
        reset_cycles(1);
        check_reset();
        // random traffic
        noisy = 1;
        lat   = -1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199, 0) == 0) begin
                reset_cycles(int'($urandom_range(3, 1)));
                check_reset();
            end else begin
                cycle(1'($urandom_range(9, 0) < 3), 1'($urandom_range(19, 0) == 0),
                      $urandom_range(3, 0) == 0 ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
